sync_debounce_edge: RTL and testbench
=====================================

SYNC_DEBOUNCE_EDGE -- requirements
Module: sync_debounce_edge

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: number of extra consecutive sampled cycles a new level must persist before acceptance; legal range 1..65535.
REQ-002 Parameter GLITCH_W, default 8: width of the glitch counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sync_in  input  1  level already synchronized into the clk domain by the upstream two-flop stage.
REQ-006 en  input  1  filter enable; 0 aborts any check in progress and holds outputs.
REQ-007 glitch_clr  input  1  synchronous clear of glitch_cnt.
REQ-008 db_out  output  1  debounced level, registered.
REQ-009 rise_pulse  output  1  one-cycle pulse when db_out goes 0->1, registered.
REQ-010 fall_pulse  output  1  one-cycle pulse when db_out goes 1->0, registered.
REQ-011 glitch_cnt  output  GLITCH_W  count of aborted checks, saturating.

Function
REQ-012 FSM shall have exactly four states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
REQ-013 STABLE_LO with en=1 and sync_in=1 shall go to CHK_HI and load stability counter to 0; otherwise it stays.
REQ-014 CHK_HI with sync_in=1 shall increment the counter; at the edge where the counter equals STABLE_CYCLES-1 it shall go to STABLE_HI, set db_out=1 and assert rise_pulse for the following cycle.
REQ-015 CHK_HI with sync_in=0 shall return to STABLE_LO and increment glitch_cnt, saturating at 2^GLITCH_W-1.
REQ-016 STABLE_HI/CHK_LO shall mirror REQ-013..015 with polarity inverted, ending in STABLE_LO, db_out=0, fall_pulse.
REQ-017 Net latency: db_out shall change at the edge on which sync_in has been sampled at the new level on STABLE_CYCLES+1 consecutive edges.
REQ-018 rise_pulse and fall_pulse shall never be high in the same cycle and each shall be high for exactly one cycle per transition.
REQ-019 en=0 in a CHK state shall return to the corresponding STABLE state without incrementing glitch_cnt; en=0 shall hold db_out and force both pulses to 0.
REQ-020 glitch_clr=1 shall zero glitch_cnt at the next edge, taking priority over a simultaneous increment.
REQ-021 Stability counter width shall be $clog2(STABLE_CYCLES+1), never wrapping.

Reset
REQ-022 rst_n=0 shall immediately force state STABLE_LO, counter 0, db_out=0, rise_pulse=0, fall_pulse=0, glitch_cnt=0.
REQ-023 Reset asserted mid-check shall discard the check; no pulse shall be generated on or after release until a full new check completes.
REQ-024 After release, the first edge shall be treated as a STABLE_LO sample.

Structure
REQ-025 A shared package sync_pkg shall hold the FSM state enum (debounce_state_e) and a default STABLE_CYCLES constant.
REQ-026 A sub-module sat_counter (parameterized width, inc, clr, saturating) shall implement glitch_cnt; the stability counter stays inline.
REQ-027 An elaboration-time check shall reject STABLE_CYCLES < 1.

Verification
REQ-028 STABLE_CYCLES=4, rst released, sync_in=1 from edge 0 held -> db_out=1 after edge 4; rise_pulse=1 only in the cycle after edge 4; glitch_cnt=0.
REQ-029 From STABLE_HI, sync_in=0 for 2 edges then 1 -> db_out stays 1, no fall_pulse, glitch_cnt=1.
REQ-030 GLITCH_W=2, five aborted high checks -> glitch_cnt reads 1,2,3,3,3; glitch_clr with simultaneous abort -> 0.
REQ-031 In CHK_HI, en=0 for one cycle -> state STABLE_LO, glitch_cnt unchanged, db_out=0, no pulses; re-check takes full 5 edges.
REQ-032 rst_n pulsed low during CHK_LO -> outputs 0 asynchronously, no fall_pulse after release, db_out rises only after full 5-edge high check.
REQ-033 Random sync_in toggling 10,000 cycles -> scoreboard model matches db_out, pulses, glitch_cnt every cycle; pulses never simultaneous.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared FSM state encoding and default filter length for the debounce block.
package sync_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } debounce_state_e;

    localparam int STABLE_CYCLES_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count updates on the edge after inc/clr.
// Backpressure: none, holds at all-ones until cleared.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sync_debounce_edge.sv
// Debounces a pre-synchronized level and emits one-cycle rise/fall pulses.
// Latency: db_out flips on the edge where the new level is seen STABLE_CYCLES+1 times in a row.
// Backpressure: none; en=0 aborts any pending check and freezes db_out.
module sync_debounce_edge
    import sync_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_in,
    input  logic                en,
    input  logic                glitch_clr,
    output logic                db_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_cfg
        $error("sync_debounce_edge: STABLE_CYCLES must be in 1..65535");
    end

    debounce_state_e  state;
    logic [CNT_W-1:0] cnt;
    logic             glitch_inc;

    // A check is only a glitch if it dies while the filter is enabled.
    always_comb begin
        glitch_inc = 1'b0;
        if (en) begin
            glitch_inc = ((state == CHK_HI) && !sync_in) ||
                         ((state == CHK_LO) &&  sync_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            db_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (en && sync_in) begin
                        state <= CHK_HI;
                        cnt   <= '0;
                    end
                end
                CHK_HI: begin
                    if (!en || !sync_in) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_HI;
                        cnt        <= '0;
                        db_out     <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (en && !sync_in) begin
                        state <= CHK_LO;
                        cnt   <= '0;
                    end
                end
                CHK_LO: begin
                    if (!en || sync_in) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_LO;
                        cnt        <= '0;
                        db_out     <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(GLITCH_W)
    ) u_glitch_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (glitch_inc),
        .clr  (glitch_clr),
        .cnt  (glitch_cnt)
    );

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed and random checks of sync_debounce_edge against a run-length reference model.
module tb_sync_debounce_edge;

    localparam int SC = 4;
    localparam int GW = 2;

    typedef struct packed {
        logic          db;
        logic          rise;
        logic          fall;
        logic [GW-1:0] g;
    } obs_t;

    logic          clk;
    logic          rst_n;
    logic          sync_in;
    logic          en;
    logic          glitch_clr;
    logic          db_out;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [GW-1:0] glitch_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: length of the current run of samples that differ from the accepted level.
    logic          m_db;
    logic          m_rise;
    logic          m_fall;
    logic [GW-1:0] m_g;
    int            m_run;
    obs_t          exp_q[$];

    sync_debounce_edge #(
        .STABLE_CYCLES(SC),
        .GLITCH_W     (GW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_in   (sync_in),
        .en        (en),
        .glitch_clr(glitch_clr),
        .db_out    (db_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_db   = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_g    = '0;
        m_run  = 0;
    endtask

    task automatic model_edge(input logic s, input logic e, input logic c);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!e) begin
            m_run = 0;
        end else if (s != m_db) begin
            m_run = m_run + 1;
            if (m_run == SC + 1) begin
                m_db   = s;
                m_rise = s;
                m_fall = !s;
                m_run  = 0;
            end
        end else begin
            if (m_run > 0 && m_g != '1) m_g = m_g + 1'b1;
            m_run = 0;
        end
        if (c) m_g = '0;
    endtask

    task automatic check_bit(input string tag, input logic act, input logic exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic check_g(input string tag, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one sample, queue the model's prediction, then compare after the edge.
    task automatic step(input string tag, input logic s, input logic e, input logic c);
        obs_t exp;
        obs_t act;
        sync_in    = s;
        en         = e;
        glitch_clr = c;
        model_edge(s, e, c);
        exp_q.push_back({m_db, m_rise, m_fall, m_g});
        @(posedge clk);
        #1;
        act = {db_out, rise_pulse, fall_pulse, glitch_cnt};
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, got db=%b", tag, act.db);
        end else begin
            exp = exp_q.pop_front();
            assert (act === exp) else begin
                fails++;
                $error("FAIL %s: got db=%b rise=%b fall=%b g=%0d expected db=%b rise=%b fall=%b g=%0d",
                       tag, act.db, act.rise, act.fall, act.g, exp.db, exp.rise, exp.fall, exp.g);
            end
        end
        tests++;
        assert (!(rise_pulse && fall_pulse)) else begin
            fails++;
            $error("FAIL %s_excl: got rise=%b fall=%b expected not both", tag, rise_pulse, fall_pulse);
        end
    endtask

    initial begin
        logic s;
        rst_n      = 1'b0;
        sync_in    = 1'b0;
        en         = 1'b1;
        glitch_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_db", db_out, 1'b0);
        check_bit("rst_rise", rise_pulse, 1'b0);
        check_bit("rst_fall", fall_pulse, 1'b0);
        check_g("rst_glitch", glitch_cnt, 2'd0);
        rst_n = 1'b1;

        // Rise after SC+1 high samples.
        for (int i = 0; i < SC; i++) step("rise_wait", 1'b1, 1'b1, 1'b0);
        check_bit("rise_early_db", db_out, 1'b0);
        step("rise_edge", 1'b1, 1'b1, 1'b0);
        check_bit("rise_db", db_out, 1'b1);
        check_bit("rise_pulse", rise_pulse, 1'b1);
        step("rise_after", 1'b1, 1'b1, 1'b0);
        check_bit("rise_pulse_once", rise_pulse, 1'b0);
        check_g("rise_glitch", glitch_cnt, 2'd0);

        // Short low glitch from STABLE_HI.
        step("lo_glitch0", 1'b0, 1'b1, 1'b0);
        step("lo_glitch1", 1'b0, 1'b1, 1'b0);
        step("lo_glitch_end", 1'b1, 1'b1, 1'b0);
        check_bit("lo_glitch_db", db_out, 1'b1);
        check_bit("lo_glitch_fall", fall_pulse, 1'b0);
        check_g("lo_glitch_cnt", glitch_cnt, 2'd1);

        // Full fall.
        for (int i = 0; i < SC; i++) step("fall_wait", 1'b0, 1'b1, 1'b0);
        step("fall_edge", 1'b0, 1'b1, 1'b0);
        check_bit("fall_db", db_out, 1'b0);
        check_bit("fall_pulse", fall_pulse, 1'b1);

        // Saturation of a 2-bit glitch counter, then clear against an abort.
        step("sat_clr", 1'b0, 1'b1, 1'b1);
        check_g("sat_clr_cnt", glitch_cnt, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step("sat_chk", 1'b1, 1'b1, 1'b0);
            step("sat_abort", 1'b0, 1'b1, 1'b0);
            check_g("sat_seq", glitch_cnt, (i < 3) ? 2'(i + 1) : 2'd3);
        end
        step("clr_chk", 1'b1, 1'b1, 1'b0);
        step("clr_abort", 1'b0, 1'b1, 1'b1);
        check_g("clr_prio", glitch_cnt, 2'd0);

        // en=0 mid-check.
        step("en_chk0", 1'b1, 1'b1, 1'b0);
        step("en_chk1", 1'b1, 1'b1, 1'b0);
        step("en_off", 1'b1, 1'b0, 1'b0);
        check_g("en_off_glitch", glitch_cnt, 2'd0);
        check_bit("en_off_db", db_out, 1'b0);
        for (int i = 0; i < SC; i++) step("en_recheck", 1'b1, 1'b1, 1'b0);
        check_bit("en_recheck_early", db_out, 1'b0);
        step("en_recheck_edge", 1'b1, 1'b1, 1'b0);
        check_bit("en_recheck_db", db_out, 1'b1);

        // Asynchronous reset during CHK_LO.
        step("rst_chk0", 1'b0, 1'b1, 1'b0);
        step("rst_chk1", 1'b0, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_bit("arst_db", db_out, 1'b0);
        check_bit("arst_fall", fall_pulse, 1'b0);
        check_g("arst_glitch", glitch_cnt, 2'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst_lo", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < SC; i++) step("post_rst_wait", 1'b1, 1'b1, 1'b0);
        check_bit("post_rst_early", db_out, 1'b0);
        step("post_rst_edge", 1'b1, 1'b1, 1'b0);
        check_bit("post_rst_db", db_out, 1'b1);

        // Random toggling with occasional disable and clear.
        s = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) s = ~s;
            step("rand", s, ($urandom_range(15) != 0), ($urandom_range(63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
